mips32_run_ctrl: RTL

Single-clock run controller that sequences one program execution on the pipe_MIPS32 core. It performs the following steps in order:
- clears the register file to a known pattern;
- streams a program image into instruction memory through a valid/ready port;
- issues a one-cycle core init pulse (PC=0, HALTED=0, TAKEN_BRANCH=0);
- enables the core, then counts cycles until HLT retires or a timeout fires.

It replaces hand-poked Reg/Mem/PC initialisation in benches and is the entry point for FPGA bring-up.

---
 rtl/mips32_run_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl: sequences one program execution on the pipe_MIPS32 core.
// It clears the register file to r[i]=i, streams a program image into
// instruction memory, pulses a core init, then runs the core until HLT retires
// or the cycle budget runs out.
module mips32_run_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int NREG    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              core_init,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  // Index of the last register cleared; register indices are 5 bits wide.
  localparam logic [4:0]  K_LAST    = 5'(NREG - 1);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [4:0]        k_q, k_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [31:0]       cycle_next;
  logic              timeout_q, timeout_d;

  // Next-state and counter update logic for the run sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    k_d           = k_q;
    prog_len_d    = prog_len_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    // Saturating cycle counter so a very long run never wraps to a small count.
    cycle_next    = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                     : cycle_count_q + 32'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_CLR;
          k_d           = 5'd0;
          prog_len_d    = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_CLR: begin
        k_d = k_q + 5'd1;
        if (k_q == K_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (prog_valid) begin
          prog_len_d = prog_len_q + LEN_ONE;
          // Filling the top address ends the load: a write must never wrap
          // back onto address 0.
          if (prog_last || (&prog_len_q[ADDR_W-1:0])) state_d = S_INIT;
        end
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        cycle_count_d = cycle_next;
        // A halt in the same cycle as the budget running out is a clean halt.
        if (core_halted) begin
          state_d = S_DONE;
        end else if (cycle_next >= TIMEOUT_W) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= 5'd0;
      prog_len_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      prog_len_q    <= prog_len_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  // Output decode from the registered state; data buses are zero when idle.
  always_comb begin
    prog_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    reg_we     = 1'b0;
    reg_addr   = 5'd0;
    reg_wdata  = 32'd0;
    core_init  = 1'b0;
    core_run   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_CLR: begin
        busy      = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = k_q;
        reg_wdata = {27'd0, k_q};
      end
      S_LOAD: begin
        busy       = 1'b1;
        prog_ready = 1'b1;
        mem_addr   = prog_len_q[ADDR_W-1:0];
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
        end
      end
      S_INIT: begin
        busy      = 1'b1;
        core_init = 1'b1;
      end
      S_RUN: begin
        busy     = 1'b1;
        core_run = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign prog_len    = prog_len_q;

endmodule
